rtc_set_ctrl: RTL and testbench
===============================

RTC_SET_CTRL -- requirements
Module: rtc_set_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100000000, clk cycles per second.
REQ-002 Parameter DEBOUNCE_CYC, default 2000000, cycles a synchronized button level must stay stable to be accepted.
REQ-003 Parameter BLINK_CYC, default 50000000, blink half-period in cycles.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 btn_mode, btn_up, btn_down  input  1 each  raw, asynchronous, active-high push buttons.
REQ-007 year  output  12  binary year, 2000..2099.
REQ-008 month  output  5  binary month, 1..12.
REQ-009 day  output  8  binary day, 1..days-in-month.
REQ-010 hour, min, sec  output  5/6/6  binary, 0..23 / 0..59 / 0..59.
REQ-011 set_mode  output  3  0=RUN, 1=SET_YEAR, 2=SET_MONTH, 3=SET_DAY, 4=SET_HOUR, 5=SET_MIN.
REQ-012 blink  output  1  cursor blink for the field being edited; 0 in RUN.
REQ-013 tick_1s  output  1  one-cycle pulse coincident with each seconds advance.

Function
REQ-014 Each button: 2-FF synchronizer, then a debounce counter; the debounced level changes only after DEBOUNCE_CYC consecutive cycles of a differing synchronized level.
REQ-015 Press event: one-cycle pulse on the debounced 0->1 edge; release generates no event; no auto-repeat.
REQ-016 FSM: RUN -> SET_YEAR -> SET_MONTH -> SET_DAY -> SET_HOUR -> SET_MIN -> RUN, one step per mode press.
REQ-017 A mode event takes priority; up/down events in the same cycle are discarded.
REQ-018 Simultaneous up and down events cancel; no field changes.
REQ-019 In RUN, the prescaler counts 0..CLK_HZ-1; on the edge it wraps, tick_1s=1 and sec advances on that same edge.
REQ-020 Seconds carry: sec 59->0 carries to min; min 59->0 to hour; hour 23->0 to day; day at month length ->1 to month; month 12->1 to year; year 2099->2000.
REQ-021 Month length: 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; February 29 if year%4==0, else 28.
REQ-022 In any SET state, prescaler and time do not advance and tick_1s=0.
REQ-023 Up/down in a SET state changes only the selected field by +/-1, taking effect on the edge after the event, with wrap: year 2099<->2000, month 12<->1, day last<->1, hour 23<->0, min 59<->0.
REQ-024 If a year or month edit leaves day above the new month length, day clamps to that length on the same edge.
REQ-025 Transition SET_MIN -> RUN clears sec and the prescaler to 0; the first tick_1s follows exactly CLK_HZ cycles later.
REQ-026 blink: in SET states it toggles every BLINK_CYC cycles.
REQ-027 blink: on every set_mode change, blink is set to 1 and its counter is cleared.
REQ-028 blink: in RUN, blink is forced to 0.
REQ-029 In RUN, up/down events are ignored.
REQ-030 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-031 Reset asserted: year=2024, month=1, day=1, hour=min=sec=0, set_mode=0, blink=0, tick_1s=0.
REQ-032 Reset asserted: prescaler, blink counter, debounce counters, synchronizers and debounced levels are all 0.
REQ-033 Reset mid-edit returns to RUN with the REQ-031 values; no pending press survives.
REQ-034 After reset release, a button already held high produces exactly one press event, after debounce.

Verification
REQ-035 Bench parameters: CLK_HZ=10, DEBOUNCE_CYC=3, BLINK_CYC=4.
REQ-036 Rollover: preset via set mode to 2023/12/31 23:59, exit to RUN, run 60 ticks -> 2024/01/01 00:00:00; tick_1s pulses 10 cycles apart.
REQ-037 Leap/clamp: set 2024/02 and up-wrap day from 29 -> 1; set day=31 in month 3, then down month to 2 -> day=29; change year to 2025 -> day=28.
REQ-038 Debounce: 2-cycle glitches on btn_up in SET_HOUR -> hour unchanged; 10-cycle press -> hour +1 exactly once.
REQ-039 Priority: mode+up same cycle in SET_YEAR -> set_mode=2, year unchanged; up+down same cycle -> no change.
REQ-040 Freeze/exit: enter SET_YEAR at sec=37 -> no tick_1s for 100 cycles; exit SET_MIN -> sec=0, first tick_1s after exactly 10 cycles.
REQ-041 Reset mid-SET_DAY with btn_up held -> REQ-031 values; one up event after release is ignored in RUN.

Source files
------------

// File: rtl/rtc_set_ctrl.sv
// rtc_set_ctrl: calendar clock (2000..2099) with a three-button set interface.
// Buttons are synchronized and debounced; mode steps through the editable
// fields, up/down edit the selected field, and the clock freezes while editing.
module rtc_set_ctrl #(
    parameter int CLK_HZ       = 100000000,
    parameter int DEBOUNCE_CYC = 2000000,
    parameter int BLINK_CYC    = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [11:0] year,
    output logic [4:0]  month,
    output logic [7:0]  day,
    output logic [4:0]  hour,
    output logic [5:0]  min,
    output logic [5:0]  sec,
    output logic [2:0]  set_mode,
    output logic        blink,
    output logic        tick_1s
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYC - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYC - 1);

    typedef enum logic [2:0] {
        MODE_RUN   = 3'd0,
        MODE_YEAR  = 3'd1,
        MODE_MONTH = 3'd2,
        MODE_DAY   = 3'd3,
        MODE_HOUR  = 3'd4,
        MODE_MIN   = 3'd5
    } mode_t;

    // Days in a month; every multiple of four is a leap year in 2000..2099.
    function automatic logic [7:0] days_in_month(input logic [4:0] m, input logic [11:0] y);
        logic [7:0] d;
        case (m)
            5'd4, 5'd6, 5'd9, 5'd11: d = 8'd30;
            5'd2:                    d = (y[1:0] == 2'b00) ? 8'd29 : 8'd28;
            default:                 d = 8'd31;
        endcase
        return d;
    endfunction

    mode_t           mode_r;
    logic [11:0]     year_r;
    logic [4:0]      month_r;
    logic [7:0]      day_r;
    logic [4:0]      hour_r;
    logic [5:0]      min_r;
    logic [5:0]      sec_r;
    logic [PW-1:0]   presc_r;
    logic            tick_r;
    logic            blink_r;
    logic [BW-1:0]   blink_cnt_r;

    // Button conditioning state, bit 0 = mode, bit 1 = up, bit 2 = down
    logic [2:0]      btn_raw_s;
    logic [2:0]      sync1_r;
    logic [2:0]      sync2_r;
    logic [2:0]      db_r;
    logic [2:0]      db_d_r;
    logic [DW-1:0]   db_cnt_r [3];
    logic [2:0]      press_s;
    logic            mode_evt_s;
    logic            up_evt_s;
    logic            down_evt_s;

    // Edit datapath results
    logic [7:0]      dim_cur_s;
    logic [7:0]      dim_edit_s;
    logic [11:0]     year_edit_s;
    logic [4:0]      month_edit_s;
    logic [7:0]      day_edit_s;
    logic [7:0]      day_fix_s;
    logic [4:0]      hour_edit_s;
    logic [5:0]      min_edit_s;

    assign btn_raw_s = {btn_down, btn_up, btn_mode};

    // Two-flop synchronizers followed by per-button stability counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            db_r    <= 3'b000;
            db_d_r  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
            db_d_r  <= db_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] != db_r[i]) begin
                    if (db_cnt_r[i] == DB_MAX) begin
                        db_r[i]     <= sync2_r[i];
                        db_cnt_r[i] <= '0;
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + {{(DW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    db_cnt_r[i] <= '0;
                end
            end
        end
    end

    // Press events: rising edge of the debounced level only. Mode wins over
    // up/down, and a simultaneous up+down pair cancels.
    assign press_s    = db_r & ~db_d_r;
    assign mode_evt_s = press_s[0];
    assign up_evt_s   = press_s[1] & ~press_s[2] & ~press_s[0];
    assign down_evt_s = press_s[2] & ~press_s[1] & ~press_s[0];
    assign dim_cur_s  = days_in_month(month_r, year_r);

    // Next value of the selected field for an up/down edit, plus day clamping.
    always_comb begin
        year_edit_s  = year_r;
        month_edit_s = month_r;
        day_edit_s   = day_r;
        hour_edit_s  = hour_r;
        min_edit_s   = min_r;
        case (mode_r)
            MODE_YEAR: begin
                if (up_evt_s) begin
                    year_edit_s = (year_r >= 12'd2099) ? 12'd2000 : year_r + 12'd1;
                end else begin
                    year_edit_s = (year_r <= 12'd2000) ? 12'd2099 : year_r - 12'd1;
                end
            end
            MODE_MONTH: begin
                if (up_evt_s) begin
                    month_edit_s = (month_r >= 5'd12) ? 5'd1 : month_r + 5'd1;
                end else begin
                    month_edit_s = (month_r <= 5'd1) ? 5'd12 : month_r - 5'd1;
                end
            end
            MODE_DAY: begin
                if (up_evt_s) begin
                    day_edit_s = (day_r >= dim_cur_s) ? 8'd1 : day_r + 8'd1;
                end else begin
                    day_edit_s = (day_r <= 8'd1) ? dim_cur_s : day_r - 8'd1;
                end
            end
            MODE_HOUR: begin
                if (up_evt_s) begin
                    hour_edit_s = (hour_r >= 5'd23) ? 5'd0 : hour_r + 5'd1;
                end else begin
                    hour_edit_s = (hour_r == 5'd0) ? 5'd23 : hour_r - 5'd1;
                end
            end
            MODE_MIN: begin
                if (up_evt_s) begin
                    min_edit_s = (min_r >= 6'd59) ? 6'd0 : min_r + 6'd1;
                end else begin
                    min_edit_s = (min_r == 6'd0) ? 6'd59 : min_r - 6'd1;
                end
            end
            default: begin
                year_edit_s = year_r;
            end
        endcase
        dim_edit_s = days_in_month(month_edit_s, year_edit_s);
        if (day_edit_s > dim_edit_s) begin
            day_fix_s = dim_edit_s;
        end else begin
            day_fix_s = day_edit_s;
        end
    end

    // Mode FSM, prescaler, timekeeping with carries, and field edits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_r  <= MODE_RUN;
            year_r  <= 12'd2024;
            month_r <= 5'd1;
            day_r   <= 8'd1;
            hour_r  <= 5'd0;
            min_r   <= 6'd0;
            sec_r   <= 6'd0;
            presc_r <= '0;
            tick_r  <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            if (mode_r == MODE_RUN) begin
                if (presc_r == PRESC_MAX) begin
                    presc_r <= '0;
                    tick_r  <= 1'b1;
                    if (sec_r == 6'd59) begin
                        sec_r <= 6'd0;
                        if (min_r == 6'd59) begin
                            min_r <= 6'd0;
                            if (hour_r == 5'd23) begin
                                hour_r <= 5'd0;
                                if (day_r >= dim_cur_s) begin
                                    day_r <= 8'd1;
                                    if (month_r == 5'd12) begin
                                        month_r <= 5'd1;
                                        year_r  <= (year_r >= 12'd2099) ? 12'd2000 : year_r + 12'd1;
                                    end else begin
                                        month_r <= month_r + 5'd1;
                                    end
                                end else begin
                                    day_r <= day_r + 8'd1;
                                end
                            end else begin
                                hour_r <= hour_r + 5'd1;
                            end
                        end else begin
                            min_r <= min_r + 6'd1;
                        end
                    end else begin
                        sec_r <= sec_r + 6'd1;
                    end
                end else begin
                    presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
                end
                if (mode_evt_s) begin
                    mode_r <= MODE_YEAR;
                end
            end else if (mode_evt_s) begin
                case (mode_r)
                    MODE_YEAR:  mode_r <= MODE_MONTH;
                    MODE_MONTH: mode_r <= MODE_DAY;
                    MODE_DAY:   mode_r <= MODE_HOUR;
                    MODE_HOUR:  mode_r <= MODE_MIN;
                    MODE_MIN: begin
                        // Leaving edit restarts the second from a clean boundary
                        mode_r  <= MODE_RUN;
                        sec_r   <= 6'd0;
                        presc_r <= '0;
                    end
                    default:    mode_r <= MODE_RUN;
                endcase
            end else if (up_evt_s || down_evt_s) begin
                year_r  <= year_edit_s;
                month_r <= month_edit_s;
                day_r   <= day_fix_s;
                hour_r  <= hour_edit_s;
                min_r   <= min_edit_s;
            end
        end
    end

    // Cursor blink: restarts high on each mode change, held low while running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_r     <= 1'b0;
            blink_cnt_r <= '0;
        end else if (mode_evt_s) begin
            blink_r     <= (mode_r != MODE_MIN);
            blink_cnt_r <= '0;
        end else if (mode_r == MODE_RUN) begin
            blink_r     <= 1'b0;
            blink_cnt_r <= '0;
        end else if (blink_cnt_r == BLINK_MAX) begin
            blink_r     <= ~blink_r;
            blink_cnt_r <= '0;
        end else begin
            blink_cnt_r <= blink_cnt_r + {{(BW-1){1'b0}}, 1'b1};
        end
    end

    assign year     = year_r;
    assign month    = month_r;
    assign day      = day_r;
    assign hour     = hour_r;
    assign min      = min_r;
    assign sec      = sec_r;
    assign set_mode = mode_r;
    assign blink    = blink_r;
    assign tick_1s  = tick_r;

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Testbench for rtc_set_ctrl: drives button presses and glitches, compares
// against a calendar reference model that tracks elapsed run cycles.
module tb_rtc_set_ctrl;

    localparam int CLK_HZ = 10;
    localparam int DEB    = 3;
    localparam int BLK    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic [11:0] year;
    logic [4:0]  month;
    logic [7:0]  day;
    logic [4:0]  hour;
    logic [5:0]  min;
    logic [5:0]  sec;
    logic [2:0]  set_mode;
    logic        blink;
    logic        tick_1s;
    logic [44:0] obs_vec;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    int m_mode, m_y, m_mo, m_d, m_h, m_mi, m_s, run_cnt;
    bit pending_exit;

    rtc_set_ctrl #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEB), .BLINK_CYC(BLK)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up),
        .btn_down(btn_down), .year(year), .month(month), .day(day), .hour(hour),
        .min(min), .sec(sec), .set_mode(set_mode), .blink(blink), .tick_1s(tick_1s)
    );

    always #5 clk = ~clk;

    assign obs_vec = {year, month, day, hour, min, sec, set_mode};

    function automatic logic [44:0] exp_vec();
        return {12'(m_y), 5'(m_mo), 8'(m_d), 5'(m_h), 6'(m_mi), 6'(m_s), 3'(m_mode)};
    endfunction

    function automatic int dim(input int mo, input int y);
        if (mo == 2) return (y % 4 == 0) ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_y = 2024; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0;
        run_cnt = 0; pending_exit = 0;
    endtask

    task automatic adv_sec();
        m_s++;
        if (m_s == 60) begin
            m_s = 0; m_mi++;
            if (m_mi == 60) begin
                m_mi = 0; m_h++;
                if (m_h == 24) begin
                    m_h = 0; m_d++;
                    if (m_d > dim(m_mo, m_y)) begin
                        m_d = 1; m_mo++;
                        if (m_mo == 13) begin
                            m_mo = 1;
                            m_y = (m_y == 2099) ? 2000 : m_y + 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic model_event(input bit pm, input bit pu, input bit pd);
        int dir, n;
        if (pm) begin
            if (m_mode == 5) pending_exit = 1;
            else m_mode++;
        end else if ((pu ^ pd) && m_mode != 0) begin
            dir = pu ? 1 : -1;
            case (m_mode)
                1: m_y = 2000 + ((m_y - 2000 + dir + 100) % 100);
                2: m_mo = 1 + ((m_mo - 1 + dir + 12) % 12);
                3: begin n = dim(m_mo, m_y); m_d = 1 + ((m_d - 1 + dir + n) % n); end
                4: m_h = (m_h + dir + 24) % 24;
                default: m_mi = (m_mi + dir + 60) % 60;
            endcase
            if (m_d > dim(m_mo, m_y)) m_d = dim(m_mo, m_y);
        end
    endtask

    // One clock: advance the model and check the tick/blink behaviour of this cycle
    task automatic cycle();
        bit exp_tick;
        @(posedge clk);
        @(negedge clk);
        if (m_mode == 0) begin
            run_cnt++;
            if (run_cnt % CLK_HZ == 0) adv_sec();
        end else if (pending_exit && set_mode == 3'd0) begin
            m_mode = 0; run_cnt = 0; m_s = 0; pending_exit = 0;
        end
        exp_tick = (m_mode == 0 && run_cnt > 0 && run_cnt % CLK_HZ == 0);
        n_chk++;
        if (tick_1s !== exp_tick) begin
            n_fail++;
            $display("FAIL tick_1s at %0t: got %b expected %b", $time, tick_1s, exp_tick);
        end
        if (m_mode == 0) begin
            n_chk++;
            if (blink !== 1'b0) begin
                n_fail++;
                $display("FAIL blink_run at %0t: got %b expected 0", $time, blink);
            end
        end
    endtask

    // Hold the given buttons for 'hold' cycles, then release for 10 cycles.
    // Holds of 1..2 cycles are glitches, 6..10 cycles are real presses.
    task automatic press(input bit pm, input bit pu, input bit pd, input int hold);
        if (pm && m_mode == 0) begin
            while (run_cnt % CLK_HZ != 0) cycle();
        end
        if (hold >= DEB + 3) model_event(pm, pu, pd);
        btn_mode = pm; btn_up = pu; btn_down = pd;
        for (int i = 0; i < hold; i++) cycle();
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        if (pending_exit) begin
            n_chk++; n_fail++;
            $display("FAIL exit_timeout: set_mode %0d expected 0", set_mode);
            m_mode = 0; run_cnt = 0; m_s = 0; pending_exit = 0;
        end
    endtask

    task automatic modes(input int n);
        for (int i = 0; i < n; i++) press(1'b1, 1'b0, 1'b0, 8);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        n_chk++;
        if ({obs_vec, blink, tick_1s} !== {12'd2024, 5'd1, 8'd1, 5'd0, 6'd0, 6'd0, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", {obs_vec, blink, tick_1s},
                     {12'd2024, 5'd1, 8'd1, 5'd0, 6'd0, 6'd0, 3'd0, 1'b0, 1'b0});
        end
        reset = 1'b1;
        for (int i = 0; i < 25; i++) cycle();
        n_chk++;
        if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL run_after_reset: got %h expected %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_rollover();
        press(1'b1, 1'b0, 1'b0, 8); press(1'b0, 1'b0, 1'b1, 8);
        press(1'b1, 1'b0, 1'b0, 8); press(1'b0, 1'b0, 1'b1, 8);
        press(1'b1, 1'b0, 1'b0, 8); press(1'b0, 1'b0, 1'b1, 8);
        press(1'b1, 1'b0, 1'b0, 8); press(1'b0, 1'b0, 1'b1, 8);
        press(1'b1, 1'b0, 1'b0, 8); press(1'b0, 1'b0, 1'b1, 8);
        n_chk++;
        if (obs_vec[44:9] !== {12'd2023, 5'd12, 8'd31, 5'd23, 6'd59}) begin
            n_fail++;
            $display("FAIL preset_2023: got %h expected %h", obs_vec[44:9], {12'd2023, 5'd12, 8'd31, 5'd23, 6'd59});
        end
        press(1'b1, 1'b0, 1'b0, 8);
        while (run_cnt < 60 * CLK_HZ) cycle();
        n_chk++;
        if (obs_vec !== {12'd2024, 5'd1, 8'd1, 5'd0, 6'd0, 6'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL rollover: got %h expected %h", obs_vec, {12'd2024, 5'd1, 8'd1, 5'd0, 6'd0, 6'd0, 3'd0});
        end
    endtask

    task automatic test_leap_clamp();
        modes(2); press(1'b0, 1'b1, 1'b0, 8);           // Feb 2024
        modes(1); press(1'b0, 1'b0, 1'b1, 8);           // day 1 -> 29
        n_chk++;
        if (day !== 8'd29 || m_d != 29) begin
            n_fail++; $display("FAIL leap_down_wrap: got %0d expected 29", day);
        end
        press(1'b0, 1'b1, 1'b0, 8);                     // 29 -> 1
        n_chk++;
        if (day !== 8'd1) begin
            n_fail++; $display("FAIL leap_up_wrap: got %0d expected 1", day);
        end
        modes(5); press(1'b0, 1'b1, 1'b0, 8);           // month 3
        modes(1); press(1'b0, 1'b0, 1'b1, 8);           // day 31
        n_chk++;
        if ({month, day} !== {5'd3, 8'd31}) begin
            n_fail++; $display("FAIL march_31: got %0d/%0d expected 3/31", month, day);
        end
        modes(5); press(1'b0, 1'b0, 1'b1, 8);           // month 2 -> clamp
        n_chk++;
        if ({month, day} !== {5'd2, 8'd29}) begin
            n_fail++; $display("FAIL clamp_feb_leap: got %0d/%0d expected 2/29", month, day);
        end
        modes(5); press(1'b0, 1'b1, 1'b0, 8);           // year 2025 -> clamp
        n_chk++;
        if ({year, day} !== {12'd2025, 8'd28}) begin
            n_fail++; $display("FAIL clamp_2025: got %0d/%0d expected 2025/28", year, day);
        end
        n_chk++;
        if (obs_vec !== exp_vec()) begin
            n_fail++; $display("FAIL leap_model: got %h expected %h", obs_vec, exp_vec());
        end
        modes(5);
    endtask

    task automatic test_debounce();
        int h0;
        modes(4);
        h0 = m_h;
        press(1'b0, 1'b1, 1'b0, 2); press(1'b0, 1'b1, 1'b0, 1); press(1'b0, 1'b1, 1'b0, 2);
        n_chk++;
        if (hour !== 5'(h0)) begin
            n_fail++; $display("FAIL glitch_ignored: got %0d expected %0d", hour, h0);
        end
        press(1'b0, 1'b1, 1'b0, 10);
        n_chk++;
        if (hour !== 5'((h0 + 1) % 24) || set_mode !== 3'd4) begin
            n_fail++; $display("FAIL press_once: got %0d expected %0d", hour, (h0 + 1) % 24);
        end
    endtask

    task automatic test_priority();
        int y0, mo0;
        modes(3);
        y0 = m_y;
        press(1'b1, 1'b1, 1'b0, 8);
        n_chk++;
        if ({set_mode, year} !== {3'd2, 12'(y0)}) begin
            n_fail++; $display("FAIL mode_priority: got mode %0d year %0d expected 2 %0d", set_mode, year, y0);
        end
        mo0 = m_mo;
        press(1'b0, 1'b1, 1'b1, 8);
        n_chk++;
        if (month !== 5'(mo0) || obs_vec !== exp_vec()) begin
            n_fail++; $display("FAIL up_down_cancel: got %0d expected %0d", month, mo0);
        end
    endtask

    task automatic test_freeze_exit();
        int guard, k;
        modes(4);
        guard = 0;
        while (m_s != 37 && guard < 1000) begin cycle(); guard++; end
        press(1'b1, 1'b0, 1'b0, 8);
        for (int i = 0; i < 100; i++) cycle();
        n_chk++;
        if (sec !== 6'd37 || set_mode !== 3'd1) begin
            n_fail++; $display("FAIL freeze: got sec %0d mode %0d expected 37 1", sec, set_mode);
        end
        // Blink phase after a mode change
        model_event(1'b1, 1'b0, 1'b0);
        btn_mode = 1'b1;
        guard = 0;
        while (set_mode !== 3'd2 && guard < 20) begin cycle(); guard++; end
        for (int j = 0; j < 16; j++) begin
            if (j == 4) btn_mode = 1'b0;
            n_chk++;
            if (blink !== (((j / BLK) % 2) == 0)) begin
                n_fail++; $display("FAIL blink_phase j=%0d: got %b expected %b", j, blink, ((j / BLK) % 2) == 0);
            end
            cycle();
        end
        for (int i = 0; i < 8; i++) cycle();
        modes(3);
        // Exit: sec cleared, first tick exactly CLK_HZ cycles later
        model_event(1'b1, 1'b0, 1'b0);
        btn_mode = 1'b1;
        guard = 0;
        while (pending_exit && guard < 20) begin cycle(); guard++; end
        btn_mode = 1'b0;
        n_chk++;
        if (sec !== 6'd0 || set_mode !== 3'd0) begin
            n_fail++; $display("FAIL exit_clear: got sec %0d mode %0d expected 0 0", sec, set_mode);
        end
        k = 0;
        do begin cycle(); k++; end while (tick_1s !== 1'b1 && k < 30);
        n_chk++;
        if (k != CLK_HZ) begin
            n_fail++; $display("FAIL first_tick: got %0d cycles expected %0d", k, CLK_HZ);
        end
    endtask

    task automatic test_random();
        bit pm, pu, pd;
        int hold;
        for (int it = 0; it < 60; it++) begin
            pm = ($urandom_range(0, 3) == 0);
            pu = $urandom_range(0, 1);
            pd = ($urandom_range(0, 2) == 0);
            hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : $urandom_range(6, 10);
            if (m_mode == 0) begin
                for (int i = 0; i < $urandom_range(0, 25); i++) cycle();
            end
            press(pm, pu, pd, hold);
            n_chk++;
            if (obs_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random_%0d: got %h expected %h", it, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_edit();
        int guard = 0;
        while (m_mode != 3 && guard < 8) begin press(1'b1, 1'b0, 1'b0, 8); guard++; end
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_chk++;
        if ({obs_vec, blink, tick_1s} !== {12'd2024, 5'd1, 8'd1, 5'd0, 6'd0, 6'd0, 3'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_mid_edit: got %h", {obs_vec, blink, tick_1s});
        end
        repeat (3) @(negedge clk);
        model_reset();
        reset = 1'b1;
        for (int i = 0; i < 15; i++) cycle();
        btn_up = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        n_chk++;
        if (obs_vec !== exp_vec() || obs_vec[44:15] !== {12'd2024, 5'd1, 8'd1, 5'd0}) begin
            n_fail++; $display("FAIL held_up_after_reset: got %h expected %h", obs_vec, exp_vec());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rollover();
        test_leap_clamp();
        test_debounce();
        test_priority();
        test_freeze_exit();
        test_random();
        test_reset_mid_edit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
